// File: rtl/vdp_blitter.sv
// Chip-8 VDP command-side writer: cursor set, sprite-byte XOR with collision detect, and full clear.
// Define VDP_CLIP_EN to clip sprites at the right and bottom edges instead of wrapping.
module vdp_blitter #(
  parameter int          VRAM_AW   = 8,
  parameter logic [7:0]  CLEAR_VAL = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         cmd,
  input  logic [7:0]         cmdData,
  output logic               busy,
  output logic               collision,
  output logic [VRAM_AW-1:0] vramAddr,
  output logic               vramRe,
  input  logic [7:0]         vramRdData,
  output logic               vramWe,
  output logic [7:0]         vramWrData,
  output logic [5:0]         curX,
  output logic [5:0]         curY
);

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_SETX  = 3'd1,
    CMD_SETY  = 3'd2,
    CMD_XOR   = 3'd3,
    CMD_CLEAR = 3'd4
  } cmdT;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    WR0  = 3'd2,
    RD1  = 3'd3,
    WR1  = 3'd4,
    CLR  = 3'd5,
    SKIP = 3'd6
  } stateT;

  stateT       state;
  stateT       nextState;
  logic [15:0] mask;
  logic [7:0]  clrAddr;
  logic [7:0]  spriteRev;
  logic [7:0]  addr8;
  logic [7:0]  hitBits;
  logic        lastWrite;
  logic        needHi;
  logic        rowOff;
  logic [2:0]  col0;
  logic [2:0]  col1;
  logic [5:0]  nextY;

  assign col0 = curX[5:3];
  assign col1 = curX[5:3] + 3'd1;

`ifdef VDP_CLIP_EN
  assign needHi = (curX[2:0] != 3'd0) && (col0 != 3'd7);
  assign rowOff = curY[5];
  assign nextY  = curY + 6'd1;
`else
  assign needHi = (curX[2:0] != 3'd0);
  assign rowOff = 1'b0;
  assign nextY  = {1'b0, curY[4:0] + 5'd1};
`endif

  // Sprite bit7 is the leftmost pixel but VRAM bit0 is, so reverse before shifting into place.
  always_comb begin
    spriteRev = '0;
    for (int n = 0; n < 8; n++) begin
      spriteRev[n] = cmdData[7-n];
    end
  end

  // Next-state and strobe decode; all VRAM outputs idle at zero outside an access.
  always_comb begin
    nextState  = state;
    busy       = (state != IDLE);
    vramRe     = 1'b0;
    vramWe     = 1'b0;
    addr8      = '0;
    vramWrData = '0;
    hitBits    = '0;
    lastWrite  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd == CMD_XOR) begin
          nextState = rowOff ? SKIP : RD0;
        end else if (cmd == CMD_CLEAR) begin
          nextState = CLR;
        end
      end
      RD0: begin
        vramRe    = 1'b1;
        addr8     = {curY[4:0], col0};
        nextState = WR0;
      end
      WR0: begin
        vramWe     = 1'b1;
        addr8      = {curY[4:0], col0};
        vramWrData = vramRdData ^ mask[7:0];
        hitBits    = vramRdData & mask[7:0];
        if (needHi) begin
          nextState = RD1;
        end else begin
          nextState = IDLE;
          lastWrite = 1'b1;
        end
      end
      RD1: begin
        vramRe    = 1'b1;
        addr8     = {curY[4:0], col1};
        nextState = WR1;
      end
      WR1: begin
        vramWe     = 1'b1;
        addr8      = {curY[4:0], col1};
        vramWrData = vramRdData ^ mask[15:8];
        hitBits    = vramRdData & mask[15:8];
        lastWrite  = 1'b1;
        nextState  = IDLE;
      end
      CLR: begin
        vramWe     = 1'b1;
        addr8      = clrAddr;
        vramWrData = CLEAR_VAL;
        if (clrAddr == 8'hFF) begin
          nextState = IDLE;
        end
      end
      SKIP: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  assign vramAddr = VRAM_AW'(addr8);

  // Commands are only sampled in IDLE; anything arriving while busy is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      curX      <= '0;
      curY      <= '0;
      collision <= 1'b0;
      mask      <= '0;
      clrAddr   <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE) begin
        case (cmd)
          CMD_SETX: begin
            curX      <= cmdData[5:0];
            collision <= 1'b0;
          end
          CMD_SETY: begin
            curY      <= {1'b0, cmdData[4:0]};
            collision <= 1'b0;
          end
          CMD_XOR: begin
            mask <= {8'h00, spriteRev} << curX[2:0];
          end
          CMD_CLEAR: begin
            clrAddr <= '0;
          end
          default: begin
          end
        endcase
      end
      if (|hitBits) begin
        collision <= 1'b1;
      end
      if (lastWrite) begin
        curY <= nextY;
      end
      if (state == CLR) begin
        clrAddr <= clrAddr + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vdp_blitter.sv
// Scoreboard bench for vdp_blitter: a pixel-level model predicts every VRAM access, cursor and busy length.
// Honours VDP_CLIP_EN when the design is built with it.
module tb_vdp_blitter;

  localparam logic [2:0] CMD_SETX  = 3'd1;
  localparam logic [2:0] CMD_SETY  = 3'd2;
  localparam logic [2:0] CMD_XOR   = 3'd3;
  localparam logic [2:0] CMD_CLEAR = 3'd4;

  logic       clk = 1'b0;
  logic       resetN;
  logic [2:0] cmd;
  logic [7:0] cmdData;
  logic       busy;
  logic       collision;
  logic [7:0] vramAddr;
  logic       vramRe;
  logic [7:0] vramRdData;
  logic       vramWe;
  logic [7:0] vramWrData;
  logic [5:0] curX;
  logic [5:0] curY;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } accessT;

  accessT     sbQ[$];
  accessT     popped;
  logic [7:0] vram[256];
  logic [7:0] shadow[256];
  logic [5:0] mCurX;
  logic [5:0] mCurY;
  logic       mColl;
  int         checks = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  vdp_blitter #(.VRAM_AW(8), .CLEAR_VAL(8'h00)) dut (
    .clk        (clk),
    .reset      (resetN),
    .cmd        (cmd),
    .cmdData    (cmdData),
    .busy       (busy),
    .collision  (collision),
    .vramAddr   (vramAddr),
    .vramRe     (vramRe),
    .vramRdData (vramRdData),
    .vramWe     (vramWe),
    .vramWrData (vramWrData),
    .curX       (curX),
    .curY       (curY)
  );

  // Synchronous VRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (vramRe) vramRdData <= vram[vramAddr];
    if (vramWe) vram[vramAddr] <= vramWrData;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Every strobe must match the oldest predicted access.
  always @(negedge clk) begin
    if (resetN === 1'b1 && (vramRe || vramWe)) begin
      checkOutput("strobeExclusive", 32'(vramRe & vramWe), 32'd0);
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedStrobe", 32'({vramRe, vramWe}), 32'd0);
      end else begin
        popped = sbQ.pop_front();
        checkOutput("accessKind", 32'(vramWe), 32'(popped.we));
        checkOutput("accessAddr", 32'(vramAddr), 32'(popped.addr));
        if (popped.we) checkOutput("wrData", 32'(vramWrData), 32'(popped.data));
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] c, input logic [7:0] d);
    @(negedge clk);
    cmd = c;
    cmdData = d;
    @(negedge clk);
    cmd = '0;
    cmdData = '0;
  endtask

  task automatic countBusy(input int start, output int n);
    n = start;
    while (busy && n < 600) begin
      n++;
      @(negedge clk);
    end
    if (busy) checkOutput("busyTimeout", 32'(busy), 32'd0);
  endtask

  task automatic setX(input logic [7:0] v);
    applyStimulus(CMD_SETX, v);
    mCurX = v[5:0];
    mColl = 1'b0;
    checkOutput("setxCurX", 32'(curX), 32'(mCurX));
    checkOutput("setxColl", 32'(collision), 32'(mColl));
  endtask

  task automatic setY(input logic [7:0] v);
    applyStimulus(CMD_SETY, v);
    mCurY = {1'b0, v[4:0]};
    mColl = 1'b0;
    checkOutput("setyCurY", 32'(curY), 32'(mCurY));
    checkOutput("setyColl", 32'(collision), 32'(mColl));
  endtask

  // Places each lit pixel individually, then derives the accesses and cursor effects.
  task automatic modelXor(input logic [7:0] d, output int expBusy);
    logic [7:0] mLo;
    logic [7:0] mHi;
    logic [7:0] a0;
    logic [7:0] a1;
    logic       hasHi;
    int         p;
`ifdef VDP_CLIP_EN
    if (mCurY >= 6'd32) begin
      expBusy = 1;
      return;
    end
`endif
    mLo = '0;
    mHi = '0;
    for (int i = 0; i < 8; i++) begin
      if (d[7-i]) begin
        p = int'(mCurX[2:0]) + i;
        if (p < 8) mLo[p] = 1'b1;
        else mHi[p-8] = 1'b1;
      end
    end
    a0 = {mCurY[4:0], mCurX[5:3]};
    a1 = {mCurY[4:0], 3'(mCurX[5:3] + 3'd1)};
    hasHi = (mCurX[2:0] != 3'd0);
`ifdef VDP_CLIP_EN
    if (mCurX[5:3] == 3'd7) hasHi = 1'b0;
`endif
    sbQ.push_back('{we: 1'b0, addr: a0, data: 8'h00});
    sbQ.push_back('{we: 1'b1, addr: a0, data: shadow[a0] ^ mLo});
    if ((shadow[a0] & mLo) != 8'h00) mColl = 1'b1;
    shadow[a0] = shadow[a0] ^ mLo;
    if (hasHi) begin
      sbQ.push_back('{we: 1'b0, addr: a1, data: 8'h00});
      sbQ.push_back('{we: 1'b1, addr: a1, data: shadow[a1] ^ mHi});
      if ((shadow[a1] & mHi) != 8'h00) mColl = 1'b1;
      shadow[a1] = shadow[a1] ^ mHi;
    end
    expBusy = hasHi ? 4 : 2;
`ifdef VDP_CLIP_EN
    mCurY = mCurY + 6'd1;
`else
    mCurY = {1'b0, mCurY[4:0] + 5'd1};
`endif
  endtask

  task automatic drawByte(input logic [7:0] d, input string tag);
    int expBusy;
    int n;
    modelXor(d, expBusy);
    applyStimulus(CMD_XOR, d);
    countBusy(0, n);
    checkOutput({tag, "Busy"}, 32'(n), 32'(expBusy));
    checkOutput({tag, "CurY"}, 32'(curY), 32'(mCurY));
    checkOutput({tag, "CurX"}, 32'(curX), 32'(mCurX));
    checkOutput({tag, "Coll"}, 32'(collision), 32'(mColl));
    checkOutput({tag, "Drain"}, 32'(sbQ.size()), 32'd0);
  endtask

  initial begin
    int n;
    resetN = 1'b0;
    cmd = '0;
    cmdData = '0;
    mCurX = '0;
    mCurY = '0;
    mColl = 1'b0;
    for (int a = 0; a < 256; a++) begin
      vram[a] = 8'h00;
      shadow[a] = 8'h00;
    end
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstColl", 32'(collision), 32'd0);
    checkOutput("rstRe", 32'(vramRe), 32'd0);
    checkOutput("rstWe", 32'(vramWe), 32'd0);
    checkOutput("rstAddr", 32'(vramAddr), 32'd0);
    checkOutput("rstWrData", 32'(vramWrData), 32'd0);
    checkOutput("rstCurX", 32'(curX), 32'd0);
    checkOutput("rstCurY", 32'(curY), 32'd0);
    resetN = 1'b1;

    // Aligned and unaligned draws into empty VRAM.
    setX(8'd8);
    setY(8'd3);
    drawByte(8'hF0, "aligned");
    setX(8'd13);
    setY(8'd0);
    drawByte(8'hFF, "unaligned");

    // Collision on an already-lit byte, then cleared by SETY.
    vram[8'h19] = 8'h0F;
    shadow[8'h19] = 8'h0F;
    setX(8'd8);
    setY(8'd3);
    drawByte(8'hF0, "collide");
    setY(8'd0);

    // Right/bottom edge behaviour.
    setX(8'd60);
    setY(8'd31);
    drawByte(8'hFF, "edge");
`ifdef VDP_CLIP_EN
    drawByte(8'h80, "offscreen");
`endif

    // Random sprites, two rows each so collision accumulates across rows.
    for (int k = 0; k < 6; k++) begin
      setX(8'($urandom_range(0, 63)));
      setY(8'($urandom_range(0, 31)));
      drawByte(8'($urandom_range(1, 255)), "randA");
      drawByte(8'($urandom_range(1, 255)), "randB");
    end

    // CLEAR with a SETX presented mid-operation that must be dropped.
    for (int a = 0; a < 256; a++) begin
      sbQ.push_back('{we: 1'b1, addr: 8'(a), data: 8'h00});
      shadow[a] = 8'h00;
    end
    applyStimulus(CMD_CLEAR, 8'h00);
    cmd = CMD_SETX;
    cmdData = 8'h05;
    n = 0;
    repeat (4) begin
      n++;
      @(negedge clk);
    end
    cmd = '0;
    cmdData = '0;
    countBusy(n, n);
    checkOutput("clearBusy", 32'(n), 32'd256);
    checkOutput("clearCurX", 32'(curX), 32'(mCurX));
    checkOutput("clearCurY", 32'(curY), 32'(mCurY));
    checkOutput("clearColl", 32'(collision), 32'(mColl));
    checkOutput("clearDrain", 32'(sbQ.size()), 32'd0);

    // Reset while CLEAR is writing address 0x40.
    for (int a = 0; a <= 8'h40; a++) begin
      sbQ.push_back('{we: 1'b1, addr: 8'(a), data: 8'h00});
    end
    applyStimulus(CMD_CLEAR, 8'h00);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (sbQ.size() == 0) break;
    end
    checkOutput("midClearReached", 32'(sbQ.size()), 32'd0);
    resetN = 1'b0;
    #1;
    checkOutput("abortWe", 32'(vramWe), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortCurX", 32'(curX), 32'd0);
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("postResetBusy", 32'(busy), 32'd0);
    checkOutput("postResetDrain", 32'(sbQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
